// File: rtl/spi_bus_arbiter_pkg.sv
// Shared constants for the board SPI bus arbiter: FSM encoding, requester
// indices and default word/clock-divider settings.
package spi_bus_arbiter_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_CLK_DIV = 2;

   localparam int REQ_LMS1 = 0;
   localparam int REQ_LMS2 = 1;
   localparam int REQ_DAC  = 2;
   localparam int REQ_AUX  = 3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   // Index width that stays legal when a count collapses to one.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Requester/SPI-pin bundle between the arbiter (slave) and the board side
// (master: requesters plus the externally muxed MISO line).
interface spi_bus_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]       ack;
   logic [WIDTH-1:0]         rdata;
   logic                     busy;
   logic [NUM_REQ-1:0]       sen_n;
   logic                     sclk;
   logic                     mosi;
   logic                     miso;

   modport master (
      output req, wdata, miso,
      input  ack, rdata, busy, sen_n, sclk, mosi
   );

   modport slave (
      input  req, wdata, miso,
      output ack, rdata, busy, sen_n, sclk, mosi
   );
endinterface

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping around.
module spi_rr_pick
   import spi_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [IDX_W-1:0]   index
);

   logic [IDX_W-1:0] cand;

   // NOTE: every output gets a default before the loop so no path leaves
   // a value unassigned, which would otherwise infer a latch.
   always_comb begin
      any   = 1'b0;
      index = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!any && req[cand]) begin
            any   = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI bus: one fixed-width MSB-first
// transaction per grant, with exactly one chip select low at a time.
module spi_bus_arbiter
   import spi_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic               clk,
   input  logic               rst,
   spi_bus_arbiter_if.slave   bus
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = idx_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   logic [2:0]         state;
   logic [IDX_W-1:0]   ptr, gnt, pick_idx;
   logic               pick_any;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_done;
   logic [BIT_W-1:0]   bit_cnt;
   logic [WIDTH-1:0]   tx_sh, rx_sh, pick_word, rdata_q;
   logic [NUM_REQ-1:0] sen_n_q, ack_q;
   logic               busy_q, sclk_q, mosi_q;

   spi_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .any   (pick_any),
      .index (pick_idx)
   );

   assign pick_word = bus.wdata[pick_idx*WIDTH +: WIDTH];
   assign cnt_done  = (cnt == CNT_LAST);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         gnt     <= '0;
         cnt     <= '0;
         bit_cnt <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         sen_n_q <= '1;
         ack_q   <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         ack_q <= '0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  gnt     <= pick_idx;
                  tx_sh   <= pick_word;
                  mosi_q  <= pick_word[WIDTH-1];
                  sen_n_q <= ~(NUM_REQ'(1) << pick_idx);
                  busy_q  <= 1'b1;
                  ptr     <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                  cnt     <= '0;
                  state   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_done) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               // sclk itself is the half-period phase: low half ends in a
               // rise (sample MISO), high half ends in a fall (next MOSI bit).
               if (cnt_done) begin
                  cnt <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                     rx_sh  <= {rx_sh[WIDTH-2:0], bus.miso};
                  end else begin
                     sclk_q <= 1'b0;
                     mosi_q <= tx_sh[WIDTH-2];
                     tx_sh  <= {tx_sh[WIDTH-2:0], 1'b0};
                     if (bit_cnt == BIT_LAST) state <= ST_HOLD;
                     else                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (cnt_done) begin
                  cnt     <= '0;
                  sen_n_q <= '1;
                  ack_q   <= NUM_REQ'(1) << gnt;
                  rdata_q <= rx_sh;
                  state   <= ST_GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_GAP: begin
               mosi_q <= 1'b0;
               if (cnt_done) begin
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = busy_q;
   assign bus.sen_n = sen_n_q;
   assign bus.sclk  = sclk_q;
   assign bus.mosi  = mosi_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench: a default 16-bit/CLK_DIV=2 arbiter and an 8-bit/CLK_DIV=1
// build, driven from a vector table plus hand-written multi-cycle sequences.
module tb_spi_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_bus_arbiter_if #(.NUM_REQ(4), .WIDTH(16)) if0 ();
   spi_bus_arbiter_if #(.NUM_REQ(4), .WIDTH(8))  if1 ();

   spi_bus_arbiter #(.NUM_REQ(4), .WIDTH(16), .CLK_DIV(2)) u_dut (
      .clk (clk), .rst (rst), .bus (if0.slave)
   );
   spi_bus_arbiter #(.NUM_REQ(4), .WIDTH(8), .CLK_DIV(1)) u_dut8 (
      .clk (clk), .rst (rst), .bus (if1.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int overlap  = 0;

   logic [3:0]  s_sn, s_ak;
   logic        s_sc, s_mo, s_busy;
   logic [15:0] s_rd;

   typedef struct {
      int          sel;
      logic [3:0]  req;
      logic [63:0] wdata;
      logic [15:0] miso_word;
      int          exp_idx;
      logic [15:0] exp_mosi;
      logic [15:0] exp_rdata;
      int          exp_len;
      int          exp_rises;
   } vec_t;

   vec_t vecs[4];

   always @(negedge clk) begin
      if ($countones(~if0.sen_n) > 1) overlap++;
      if ($countones(~if1.sen_n) > 1) overlap++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sample(input int sel);
      @(negedge clk);
      if (sel == 0) begin
         s_sn = if0.sen_n; s_sc = if0.sclk; s_mo = if0.mosi;
         s_ak = if0.ack;   s_rd = if0.rdata; s_busy = if0.busy;
      end else begin
         s_sn = if1.sen_n; s_sc = if1.sclk; s_mo = if1.mosi;
         s_ak = if1.ack;   s_rd = {8'h00, if1.rdata}; s_busy = if1.busy;
      end
   endtask

   task automatic drive_miso(input int sel, input logic b);
      if (sel == 0) if0.miso = b;
      else          if1.miso = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for a grant, follows it to the ack cycle, and checks select
   // pattern, length, sclk edges, MOSI bits, ack and captured MISO word.
   task automatic run_txn(input int sel, input int exp_idx, input logic [15:0] exp_mosi,
                          input logic [15:0] miso_word, input logic [15:0] exp_rdata,
                          input int exp_len, input int exp_rises, input string tag,
                          output int pre);
      int          n, rises, bad;
      logic [15:0] cap, msh;
      logic        prev_sc;
      logic [3:0]  pat;
      pat = ~(4'b0001 << exp_idx);
      msh = (sel != 0) ? (miso_word << 8) : miso_word;
      drive_miso(sel, msh[15]);
      pre = 0;
      sample(sel);
      while (s_sn == 4'hF && pre < 300) begin
         pre++;
         sample(sel);
      end
      if (s_sn == 4'hF) begin
         check({tag, "_start_timeout"}, 0, 1);
         return;
      end
      check({tag, "_sen_n"}, s_sn, pat);
      check({tag, "_busy"}, s_busy, 1);
      n = 0; rises = 0; bad = 0; cap = '0; prev_sc = 1'b0;
      while (s_sn != 4'hF && n < 300) begin
         if (s_sn != pat) bad++;
         if (s_sc && !prev_sc) begin
            rises++;
            cap = {cap[14:0], s_mo};
         end
         if (!s_sc && prev_sc) begin
            msh = msh << 1;
            drive_miso(sel, msh[15]);
         end
         prev_sc = s_sc;
         n++;
         sample(sel);
      end
      check({tag, "_len"}, n, exp_len);
      check({tag, "_sel_stable"}, bad, 0);
      check({tag, "_rises"}, rises, exp_rises);
      check({tag, "_mosi"}, cap, exp_mosi);
      check({tag, "_ack"}, s_ak, 4'b0001 << exp_idx);
      check({tag, "_rdata"}, s_rd, exp_rdata);
      sample(sel);
      check({tag, "_ack_clr"}, s_ak, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          pre, n, rises, acks;
      logic        prev;
      int          order[5];
      logic [15:0] words[4];

      vecs[0] = '{sel:0, req:4'b0001, wdata:64'h0000_0000_0000_A55A, miso_word:16'h0000,
                  exp_idx:0, exp_mosi:16'hA55A, exp_rdata:16'h0000, exp_len:68, exp_rises:16};
      vecs[1] = '{sel:0, req:4'b0010, wdata:64'h0000_0000_1234_0000, miso_word:16'h8001,
                  exp_idx:1, exp_mosi:16'h1234, exp_rdata:16'h8001, exp_len:68, exp_rises:16};
      vecs[2] = '{sel:0, req:4'b0100, wdata:64'h0000_00FF_0000_0000, miso_word:16'hF00F,
                  exp_idx:2, exp_mosi:16'h00FF, exp_rdata:16'hF00F, exp_len:68, exp_rises:16};
      vecs[3] = '{sel:1, req:4'b1000, wdata:64'h0000_0000_C300_0000, miso_word:16'h005A,
                  exp_idx:3, exp_mosi:16'h00C3, exp_rdata:16'h005A, exp_len:18, exp_rises:8};

      if0.req = '0; if0.wdata = '0; if0.miso = 1'b0;
      if1.req = '0; if1.wdata = '0; if1.miso = 1'b0;

      // Reset values, during and just after reset.
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sample(s);
         check($sformatf("rst%0d_sen_n", s), s_sn, 4'hF);
         check($sformatf("rst%0d_sclk", s), s_sc, 0);
         check($sformatf("rst%0d_mosi", s), s_mo, 0);
         check($sformatf("rst%0d_ack", s), s_ak, 0);
         check($sformatf("rst%0d_rdata", s), s_rd, 0);
         check($sformatf("rst%0d_busy", s), s_busy, 0);
      end
      rst = 1'b0;
      sample(0);
      check("idle_sen_n", s_sn, 4'hF);
      check("idle_busy", s_busy, 0);

      // Table: single requests on both builds, including wdata change after grant.
      for (int i = 0; i < 4; i++) begin
         if (vecs[i].sel == 0) begin
            if0.wdata = vecs[i].wdata;
            if0.req   = vecs[i].req;
         end else begin
            if1.wdata = vecs[i].wdata[31:0];
            if1.req   = vecs[i].req;
         end
         if (i == 1) begin
            fork
               begin
                  repeat (20) @(negedge clk);
                  if0.wdata = 64'hDEAD_BEEF_0BAD_F00D;
               end
            join_none
         end
         run_txn(vecs[i].sel, vecs[i].exp_idx, vecs[i].exp_mosi, vecs[i].miso_word,
                 vecs[i].exp_rdata, vecs[i].exp_len, vecs[i].exp_rises,
                 $sformatf("vec%0d", i), pre);
         if0.req = '0;
         if1.req = '0;
      end

      // Contention from a fresh pointer, then fairness after a grant to 0.
      do_reset();
      words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      order = '{0, 1, 2, 3, 0};
      if0.wdata = {words[3], words[2], words[1], words[0]};
      if0.miso  = 1'b0;
      if0.req   = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         run_txn(0, order[k], words[order[k]], 16'h0000, 16'h0000, 68, 16,
                 $sformatf("rr%0d", k), pre);
         if (k > 0) check($sformatf("rr%0d_gap", k), (pre + 2) >= 3, 1);
      end
      if0.req = 4'b1001;
      run_txn(0, 3, words[3], 16'h0000, 16'h0000, 68, 16, "fair0", pre);
      run_txn(0, 0, words[0], 16'h0000, 16'h0000, 68, 16, "fair1", pre);
      if0.req = '0;

      // Reset asserted mid-SHIFT, then re-grant of index 2.
      do_reset();
      if0.wdata = 64'h0000_FFFF_0000_0000;
      if0.req   = 4'b0100;
      n = 0;
      sample(0);
      while (s_sn == 4'hF && n < 300) begin
         n++;
         sample(0);
      end
      check("midrst_start", s_sn, 4'b1011);
      rises = 0; prev = 1'b0; n = 0;
      while (rises < 7 && n < 300) begin
         if (s_sc && !prev) rises++;
         prev = s_sc;
         n++;
         sample(0);
      end
      check("midrst_bit7", rises, 7);
      rst = 1'b1;
      sample(0);
      check("midrst_sen_n", s_sn, 4'hF);
      check("midrst_sclk", s_sc, 0);
      check("midrst_mosi", s_mo, 0);
      check("midrst_busy", s_busy, 0);
      acks = (s_ak != 0) ? 1 : 0;
      repeat (2) begin
         sample(0);
         if (s_ak != 0) acks++;
      end
      rst = 1'b0;
      check("midrst_no_ack", acks, 0);
      run_txn(0, 2, 16'hFFFF, 16'h0000, 16'h0000, 68, 16, "postrst", pre);
      if0.req = '0;

      check("sen_n_overlap", overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
